// File: rtl/hc595_rx_if.sv
// Four-wire 74HC595 display link as seen by a receiver/monitor.
// The display driver owns the master side; hc595_rx listens on the slave side.
interface hc595_rx_if;
    logic ds;
    logic shcp;
    logic stcp;
    logic oe;

    modport master (output ds, output shcp, output stcp, output oe);
    modport slave  (input  ds, input  shcp, input  stcp, input  oe);
endinterface

// File: rtl/hc595_rx.sv
// 74HC595 link receiver: oversamples the serial link on sys_clk, rebuilds the
// shift/storage registers, checks frame length and decodes latched digits.
module hc595_rx #(
    parameter int DATA_W = 14,
    parameter int SEL_W  = 6,
    parameter int SEG_W  = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    hc595_rx_if.slave            link,
    output logic [SEL_W-1:0]     sel_out,
    output logic [SEG_W-1:0]     seg_out,
    output logic                 disp_en,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic                 sel_err,
    output logic [SEL_W*5-1:0]   digits,
    output logic [SEL_W-1:0]     digit_upd
);

    localparam logic [7:0]       FRAME_BITS = 8'(DATA_W);
    localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);

    logic              ds_s1, ds_s2;
    logic              shcp_s1, shcp_s2, shcp_s3;
    logic              stcp_s1, stcp_s2, stcp_s3;
    logic              oe_s1, oe_s2;
    logic              shcp_rise, stcp_rise;
    logic [DATA_W-1:0] shreg;
    logic [7:0]        bitcnt;
    logic              sel_onehot;
    logic [4:0]        lut;

    // Pattern lookup with dp forced off; returns {hit, hex}.
    function automatic logic [4:0] seg_lookup(input logic [6:0] seg);
        logic [4:0] r;
        case ({1'b1, seg})
            8'hC0: r = 5'h10;  8'hF9: r = 5'h11;  8'hA4: r = 5'h12;  8'hB0: r = 5'h13;
            8'h99: r = 5'h14;  8'h92: r = 5'h15;  8'h82: r = 5'h16;  8'hF8: r = 5'h17;
            8'h80: r = 5'h18;  8'h90: r = 5'h19;  8'h88: r = 5'h1A;  8'h83: r = 5'h1B;
            8'hC6: r = 5'h1C;  8'hA1: r = 5'h1D;  8'h86: r = 5'h1E;  8'h8E: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Synchronizers: idle-high lines reset high so a line held high
    // across reset release never looks like a rising edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ds_s1   <= 1'b0;
            ds_s2   <= 1'b0;
            shcp_s1 <= 1'b1;
            shcp_s2 <= 1'b1;
            shcp_s3 <= 1'b1;
            stcp_s1 <= 1'b1;
            stcp_s2 <= 1'b1;
            stcp_s3 <= 1'b1;
            oe_s1   <= 1'b1;
            oe_s2   <= 1'b1;
        end else begin
            ds_s1   <= link.ds;
            ds_s2   <= ds_s1;
            shcp_s1 <= link.shcp;
            shcp_s2 <= shcp_s1;
            shcp_s3 <= shcp_s2;
            stcp_s1 <= link.stcp;
            stcp_s2 <= stcp_s1;
            stcp_s3 <= stcp_s2;
            oe_s1   <= link.oe;
            oe_s2   <= oe_s1;
        end
    end

    assign shcp_rise = shcp_s2 & ~shcp_s3;
    assign stcp_rise = stcp_s2 & ~stcp_s3;

    // Shift/latch stage: latch sees shreg and bitcnt from before any
    // shift that lands in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shreg       <= '0;
            bitcnt      <= '0;
            sel_out     <= '0;
            seg_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= stcp_rise;
            frame_err   <= stcp_rise && (bitcnt != FRAME_BITS);
            if (stcp_rise)
                {sel_out, seg_out} <= shreg;
            if (shcp_rise)
                shreg <= {shreg[DATA_W-2:0], ds_s2};
            if (stcp_rise)
                bitcnt <= shcp_rise ? 8'd1 : 8'd0;
            else if (shcp_rise && bitcnt != 8'hFF)
                bitcnt <= bitcnt + 8'd1;
        end
    end

    assign sel_onehot = (sel_out != '0) && ((sel_out & (sel_out - SEL_ONE)) == '0);
    assign sel_err    = ~sel_onehot;
    assign lut        = seg_lookup(seg_out[6:0]);

    // Decode stage: one cycle behind the latch; unknown patterns leave the slot alone.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            digits    <= '0;
            digit_upd <= '0;
        end else begin
            digit_upd <= '0;
            if (frame_valid && sel_onehot && lut[4]) begin
                digit_upd <= sel_out;
                for (int i = 0; i < SEL_W; i++)
                    if (sel_out[i])
                        digits[5*i +: 5] <= {~seg_out[SEG_W-1], lut[3:0]};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            disp_en <= 1'b0;
        else
            disp_en <= ~oe_s2;
    end

endmodule
